// File: rtl/daq_pkg.sv
// Shared encodings for the DAQ capture controller: trigger modes, FSM states, default lane width.
package daq_pkg;

  typedef enum logic [1:0] {
    TRIG_IMM   = 2'd0,
    TRIG_LEVEL = 2'd1,
    TRIG_RISE  = 2'd2,
    TRIG_FALL  = 2'd3
  } trig_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int unsigned DEF_LANE_W = 16;

endpackage

// File: rtl/daq_trig_detect.sv
// Trigger detector: selects the trigger channel, tracks its previous sample and
// raises a new_data-qualified fire for the programmed threshold condition.
module daq_trig_detect
  import daq_pkg::*;
#(
  parameter int unsigned NCH      = 1,
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned TCH_W    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    new_data,
  input  logic [NCH*SAMPLE_W-1:0] data_in,
  input  logic [1:0]              trig_mode,
  input  logic [TCH_W-1:0]        trig_ch,
  input  logic [SAMPLE_W-1:0]     trig_level,
  output logic                    fire_c
);

  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0] prev;

  // Out-of-range channel numbers fall back to channel 0
  always_comb begin
    sample = data_in[SAMPLE_W-1:0];
    for (int i = 0; i < int'(NCH); i++) begin
      if (trig_ch == TCH_W'(i)) sample = data_in[i*SAMPLE_W +: SAMPLE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) prev <= '0;
    else if (new_data) prev <= sample;
  end

  always_comb begin
    fire_c = 1'b0;
    if (new_data) begin
      unique case (trig_mode_e'(trig_mode))
        TRIG_IMM:   fire_c = 1'b1;
        TRIG_LEVEL: fire_c = (sample >= trig_level);
        TRIG_RISE:  fire_c = (prev < trig_level) && (sample >= trig_level);
        TRIG_FALL:  fire_c = (prev >= trig_level) && (sample < trig_level);
      endcase
    end
  end

endmodule

// File: rtl/daq_capture_ctrl.sv
// Multi-channel capture controller: arm, trigger, pack strobes into FIFO words, count and stop.
// Optional DAQ_DECIM_EN adds decim[7:0]: only every (decim+1)-th strobe is packed in CAPTURE.
module daq_capture_ctrl
  import daq_pkg::*;
#(
  parameter int unsigned NCH      = 1,
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned LANE_W   = DEF_LANE_W,
  parameter int unsigned OUT_W    = 64,
  parameter int unsigned CNT_W    = 32,
  localparam int unsigned TCH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    new_data,
  input  logic [NCH*SAMPLE_W-1:0] data_in,
  input  logic [1:0]              trig_mode,
  input  logic [TCH_W-1:0]        trig_ch,
  input  logic [SAMPLE_W-1:0]     trig_level,
  input  logic [CNT_W-1:0]        word_limit,
  input  logic                    fifo_full,
`ifdef DAQ_DECIM_EN
  input  logic [7:0]              decim,
`endif
  output logic [OUT_W-1:0]        data_out,
  output logic                    write_fifo_en,
  output logic                    write_SRAM_en,
  output logic                    done,
  output logic                    overflow,
  output logic [CNT_W-1:0]        word_cnt
);

  localparam int unsigned LANES  = OUT_W / LANE_W;
  localparam int unsigned SPW    = LANES / NCH;
  localparam int unsigned SLOT_W = NCH * LANE_W;
  localparam int unsigned PTR_W  = (SPW > 1) ? $clog2(SPW) : 1;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr;
  logic [OUT_W-1:0]   acc, word_nxt;
  logic [SLOT_W-1:0]  lanes_c;
  logic               fire_c, strobe_c, pack_c, last_c;
`ifdef DAQ_DECIM_EN
  logic [7:0]         dec_q, dec_d, dec_base;
`endif

  daq_trig_detect #(
    .NCH      (NCH),
    .SAMPLE_W (SAMPLE_W),
    .TCH_W    (TCH_W)
  ) u_trig (
    .clk        (clk),
    .rst        (rst),
    .new_data   (new_data),
    .data_in    (data_in),
    .trig_mode  (trig_mode),
    .trig_ch    (trig_ch),
    .trig_level (trig_level),
    .fire_c     (fire_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state plus strobe acceptance; the triggering strobe is itself packed
  always_comb begin
    state_d  = state_q;
    strobe_c = 1'b0;
    pack_c   = 1'b0;
    last_c   = (ptr == PTR_W'(SPW - 1));
`ifdef DAQ_DECIM_EN
    dec_d    = dec_q;
    dec_base = dec_q;
`endif
    if (!wr_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_ARMED;
        ST_ARMED: begin
          if (fire_c) begin
            state_d  = ST_CAPTURE;
            strobe_c = 1'b1;
          end
        end
        ST_CAPTURE: begin
          strobe_c = new_data;
          if (write_fifo_en && (word_limit != '0) && (word_cnt == word_limit))
            state_d = ST_DONE;
        end
        ST_DONE:    state_d = ST_DONE;
        default:    state_d = ST_IDLE;
      endcase
    end
`ifdef DAQ_DECIM_EN
    if (state_q == ST_ARMED) dec_base = 8'd0;
    pack_c = strobe_c && (dec_base == 8'd0);
    if (strobe_c) dec_d = (dec_base == decim) ? 8'd0 : dec_base + 8'd1;
`else
    pack_c = strobe_c;
`endif
  end

  // Zero-extend each channel into its lane and drop the slot into the word under construction
  always_comb begin
    lanes_c = '0;
    for (int c = 0; c < int'(NCH); c++)
      lanes_c[c*LANE_W +: LANE_W] = LANE_W'(data_in[c*SAMPLE_W +: SAMPLE_W]);
    word_nxt = acc;
    for (int s = 0; s < int'(SPW); s++)
      if (ptr == PTR_W'(s)) word_nxt[s*SLOT_W +: SLOT_W] = lanes_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      acc           <= '0;
      data_out      <= '0;
      write_fifo_en <= 1'b0;
      write_SRAM_en <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      word_cnt      <= '0;
`ifdef DAQ_DECIM_EN
      dec_q         <= '0;
`endif
    end else begin
      write_fifo_en <= 1'b0;
      done          <= (state_d == ST_DONE);
      if (write_fifo_en && fifo_full) overflow <= 1'b1;
      if (!wr_en) begin
        ptr           <= '0;
        write_SRAM_en <= 1'b0;
      end else if (state_q == ST_IDLE) begin
        ptr      <= '0;
        word_cnt <= '0;
        overflow <= 1'b0;
      end else if (pack_c) begin
        if (last_c) begin
          data_out      <= word_nxt;
          write_fifo_en <= 1'b1;
          write_SRAM_en <= 1'b1;
          word_cnt      <= word_cnt + CNT_W'(1);
          ptr           <= '0;
        end else begin
          acc <= word_nxt;
          ptr <= ptr + PTR_W'(1);
        end
      end
`ifdef DAQ_DECIM_EN
      dec_q <= dec_d;
`endif
    end
  end

endmodule

// File: tb/tb_daq_capture_ctrl.sv
// Scoreboard bench for daq_capture_ctrl: one single-channel and one dual-channel instance.
module tb_daq_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst, new_data, wr_en1, wr_en2, fifo_full;
  logic [23:0] data_in;
  logic [1:0]  trig_mode;
  logic [11:0] trig_level;
  logic [31:0] word_limit;
  logic        trig_ch;
`ifdef DAQ_DECIM_EN
  logic [7:0]  decim;
`endif

  logic [63:0] dout1, dout2;
  logic        we1, we2, sram1, sram2, done1, done2, ovf1, ovf2;
  logic [31:0] cnt1, cnt2;

  int          n_cmp = 0, n_err = 0, pushes1 = 0, pushes2 = 0;
  logic [63:0] q1[$], q2[$];

  always #5 clk = ~clk;

  daq_capture_ctrl #(.NCH(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .new_data(new_data), .data_in(data_in[11:0]),
    .trig_mode(trig_mode), .trig_ch(trig_ch), .trig_level(trig_level), .word_limit(word_limit),
    .fifo_full(fifo_full),
`ifdef DAQ_DECIM_EN
    .decim(decim),
`endif
    .data_out(dout1), .write_fifo_en(we1), .write_SRAM_en(sram1), .done(done1),
    .overflow(ovf1), .word_cnt(cnt1)
  );

  daq_capture_ctrl #(.NCH(2)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en2), .new_data(new_data), .data_in(data_in),
    .trig_mode(trig_mode), .trig_ch(trig_ch), .trig_level(trig_level), .word_limit(word_limit),
    .fifo_full(fifo_full),
`ifdef DAQ_DECIM_EN
    .decim(8'd0),
`endif
    .data_out(dout2), .write_fifo_en(we2), .write_SRAM_en(sram2), .done(done2),
    .overflow(ovf2), .word_cnt(cnt2)
  );

  // Pop-and-compare on every push
  always @(negedge clk) begin
    if (we1) begin
      pushes1++;
      n_cmp++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL push1_unexpected: got %h, required no push", dout1);
      end else begin
        logic [63:0] e;
        e = q1.pop_front();
        if (dout1 !== e) begin
          n_err++;
          $display("FAIL push1_data: got %h required %h", dout1, e);
        end
      end
    end
    if (we2) begin
      pushes2++;
      n_cmp++;
      if (q2.size() == 0) begin
        n_err++;
        $display("FAIL push2_unexpected: got %h, required no push", dout2);
      end else begin
        logic [63:0] e;
        e = q2.pop_front();
        if (dout2 !== e) begin
          n_err++;
          $display("FAIL push2_data: got %h required %h", dout2, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [23:0] d);
    @(posedge clk); #1;
    new_data = 1'b1;
    data_in  = d;
    @(posedge clk); #1;
    new_data = 1'b0;
  endtask

  task automatic arm1();
    wr_en1 = 1'b0;
    cyc(2);
    wr_en1 = 1'b1;
    cyc(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    n_cmp++;
    if ({dout1, we1, sram1, done1, ovf1, cnt1} !== '0) begin
      n_err++;
      $display("FAIL reset_dut1: got %h required 0", {dout1, we1, sram1, done1, ovf1, cnt1});
    end
    n_cmp++;
    if ({dout2, we2, sram2, done2, ovf2, cnt2} !== '0) begin
      n_err++;
      $display("FAIL reset_dut2: got %h required 0", {dout2, we2, sram2, done2, ovf2, cnt2});
    end
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_imm_pack();
    trig_mode = 2'd0; word_limit = 32'd2;
    arm1();
    q1.push_back(64'h0004_0003_0002_0001);
    q1.push_back(64'h0008_0007_0006_0005);
    for (int i = 1; i <= 4; i++) strobe(24'(i));
    n_cmp++;
    if (we1 !== 1'b1 || cnt1 !== 32'd1) begin
      n_err++;
      $display("FAIL push_latency: we=%b cnt=%0d required we=1 cnt=1", we1, cnt1);
    end
    for (int i = 5; i <= 8; i++) strobe(24'(i));
    cyc(3);
    n_cmp++;
    if (done1 !== 1'b1 || cnt1 !== 32'd2 || sram1 !== 1'b1) begin
      n_err++;
      $display("FAIL t1_done: done=%b cnt=%0d sram=%b required 1/2/1", done1, cnt1, sram1);
    end
    strobe(24'h009);
    cyc(2);
    n_cmp++;
    if (pushes1 !== 2 || dout1 !== 64'h0008_0007_0006_0005 || done1 !== 1'b1) begin
      n_err++;
      $display("FAIL t1_done_ignore: pushes=%0d dout=%h done=%b required 2/0008000700060005/1", pushes1, dout1, done1);
    end
  endtask

  task automatic test_rise_trig();
    int p;
    trig_mode = 2'd2; trig_level = 12'h800; word_limit = 32'd1;
    wr_en1 = 1'b0;
    strobe(24'h900);
    arm1();
    p = pushes1;
    strobe(24'h810); strobe(24'h800); strobe(24'h7F8); strobe(24'h7F0);
    cyc(3);
    n_cmp++;
    if (pushes1 !== p || cnt1 !== 32'd0 || done1 !== 1'b0) begin
      n_err++;
      $display("FAIL t2_falling_no_trig: pushes=%0d cnt=%0d done=%b required %0d/0/0", pushes1, cnt1, done1, p);
    end
    q1.push_back(64'h0830_0820_0810_0800);
    strobe(24'h7F0); strobe(24'h7F8); strobe(24'h800); strobe(24'h810);
    strobe(24'h820); strobe(24'h830); strobe(24'h840);
    cyc(3);
    n_cmp++;
    if (pushes1 !== p + 1 || done1 !== 1'b1 || cnt1 !== 32'd1) begin
      n_err++;
      $display("FAIL t2_rise: pushes=%0d done=%b cnt=%0d required %0d/1/1", pushes1, done1, cnt1, p + 1);
    end
    wr_en1 = 1'b0;
  endtask

  task automatic test_two_ch();
    trig_mode = 2'd0; word_limit = 32'd1;
    wr_en2 = 1'b1;
    cyc(2);
    q2.push_back(64'h000D_000C_000B_000A);
    strobe({12'h00B, 12'h00A});
    strobe({12'h00D, 12'h00C});
    cyc(3);
    n_cmp++;
    if (pushes2 !== 1 || done2 !== 1'b1 || cnt2 !== 32'd1) begin
      n_err++;
      $display("FAIL t3_two_ch: pushes=%0d done=%b cnt=%0d required 1/1/1", pushes2, done2, cnt2);
    end
    wr_en2 = 1'b0;
  endtask

  task automatic test_overflow();
    int p;
    trig_mode = 2'd0; word_limit = 32'd3;
    arm1();
    p = pushes1;
    for (int w = 0; w < 3; w++)
      q1.push_back({16'(8'h13 + 4*w), 16'(8'h12 + 4*w), 16'(8'h11 + 4*w), 16'(8'h10 + 4*w)});
    for (int i = 0; i < 5; i++) strobe(24'(8'h10 + i));
    n_cmp++;
    if (ovf1 !== 1'b0) begin
      n_err++;
      $display("FAIL t4_no_early_ovf: got %b required 0", ovf1);
    end
    fifo_full = 1'b1;
    for (int i = 5; i < 8; i++) strobe(24'(8'h10 + i));
    cyc(1);
    fifo_full = 1'b0;
    for (int i = 8; i < 12; i++) strobe(24'(8'h10 + i));
    cyc(3);
    n_cmp++;
    if (pushes1 !== p + 3 || ovf1 !== 1'b1 || cnt1 !== 32'd3 || done1 !== 1'b1) begin
      n_err++;
      $display("FAIL t4_overflow: pushes=%0d ovf=%b cnt=%0d done=%b required %0d/1/3/1", pushes1, ovf1, cnt1, done1, p + 3);
    end
    wr_en1 = 1'b0;
    cyc(2);
    n_cmp++;
    if (ovf1 !== 1'b1 || cnt1 !== 32'd3 || done1 !== 1'b0) begin
      n_err++;
      $display("FAIL t4_idle_hold: ovf=%b cnt=%0d done=%b required 1/3/0", ovf1, cnt1, done1);
    end
    wr_en1 = 1'b1;
    cyc(2);
    n_cmp++;
    if (ovf1 !== 1'b0 || cnt1 !== 32'd0) begin
      n_err++;
      $display("FAIL t4_rearm_clear: ovf=%b cnt=%0d required 0/0", ovf1, cnt1);
    end
    wr_en1 = 1'b0;
  endtask

  task automatic test_abort();
    int p;
    trig_mode = 2'd0; word_limit = 32'd1;
    arm1();
    p = pushes1;
    strobe(24'h0A1); strobe(24'h0A2); strobe(24'h0A3);
    @(posedge clk); #1;
    new_data = 1'b1; data_in = 24'h0A4; wr_en1 = 1'b0;
    @(posedge clk); #1;
    new_data = 1'b0;
    cyc(2);
    n_cmp++;
    if (pushes1 !== p || done1 !== 1'b0) begin
      n_err++;
      $display("FAIL t5_abort: pushes=%0d done=%b required %0d/0", pushes1, done1, p);
    end
    wr_en1 = 1'b1;
    cyc(2);
    q1.push_back(64'h00B4_00B3_00B2_00B1);
    for (int i = 1; i <= 4; i++) strobe(24'(8'hB0 + i));
    cyc(3);
    n_cmp++;
    if (pushes1 !== p + 1 || done1 !== 1'b1 || cnt1 !== 32'd1) begin
      n_err++;
      $display("FAIL t5_rearm: pushes=%0d done=%b cnt=%0d required %0d/1/1", pushes1, done1, cnt1, p + 1);
    end
    wr_en1 = 1'b0;
  endtask

`ifdef DAQ_DECIM_EN
  task automatic test_decim();
    trig_mode = 2'd0; word_limit = 32'd1; decim = 8'd1;
    arm1();
    q1.push_back(64'h0007_0005_0003_0001);
    for (int i = 1; i <= 8; i++) strobe(24'(i));
    cyc(3);
    n_cmp++;
    if (done1 !== 1'b1 || cnt1 !== 32'd1) begin
      n_err++;
      $display("FAIL t6_decim: done=%b cnt=%0d required 1/1", done1, cnt1);
    end
    decim = 8'd0;
    wr_en1 = 1'b0;
  endtask
`endif

  task automatic test_rst_mid_capture();
    trig_mode = 2'd0; word_limit = 32'd0;
    arm1();
    q1.push_back(64'h0044_0043_0042_0041);
    for (int i = 1; i <= 5; i++) strobe(24'(8'h40 + i));
    n_cmp++;
    if (cnt1 !== 32'd1 || sram1 !== 1'b1) begin
      n_err++;
      $display("FAIL t6_pre_rst: cnt=%0d sram=%b required 1/1", cnt1, sram1);
    end
    rst = 1'b1;
    cyc(1);
    n_cmp++;
    if ({dout1, we1, sram1, done1, ovf1, cnt1} !== '0) begin
      n_err++;
      $display("FAIL t6_rst_mid: got %h required 0", {dout1, we1, sram1, done1, ovf1, cnt1});
    end
    rst = 1'b0;
    cyc(2);
    q1.push_back(64'h0054_0053_0052_0051);
    for (int i = 1; i <= 4; i++) strobe(24'(8'h50 + i));
    cyc(2);
    n_cmp++;
    if (cnt1 !== 32'd1 || done1 !== 1'b0) begin
      n_err++;
      $display("FAIL t6_post_rst: cnt=%0d done=%b required 1/0", cnt1, done1);
    end
    wr_en1 = 1'b0;
    cyc(2);
  endtask

  initial begin
    rst = 1'b1; new_data = 1'b0; wr_en1 = 1'b0; wr_en2 = 1'b0; fifo_full = 1'b0;
    data_in = '0; trig_mode = 2'd0; trig_level = '0; word_limit = '0; trig_ch = 1'b0;
`ifdef DAQ_DECIM_EN
    decim = 8'd0;
`endif
    test_reset();
    test_imm_pack();
    test_rise_trig();
    test_two_ch();
    test_overflow();
    test_abort();
`ifdef DAQ_DECIM_EN
    test_decim();
`endif
    test_rst_mid_capture();
    n_cmp++;
    if (q1.size() != 0 || q2.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: q1=%0d q2=%0d required 0/0", q1.size(), q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
